// File: rtl/vga_smem_arbiter.sv
// vga_smem_arbiter: shares single-port smem between display prefetch (slot x[3:0]==SLOT, priority) and CPU req/ack (clk, reset, x, y, activevideo, cpu_req/we/addr/wdata -> cpu_ack/rdata, mem_addr/we/wdata <- mem_rdata, char_code, stall_cnt counted only with SMEM_STALL_CNT_EN)
module vga_smem_arbiter #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int SLOT = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              activevideo,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] char_code,
  output logic [15:0]       stall_cnt
);
  typedef enum logic {IDLE, CPU_ACK} state_t;
  state_t state, state_n;
  logic wrap, disp_slot, in_map, disp_acc, vis, grant, disp_pend;
  logic [5:0] col, row;
  logic [ADDR_W-1:0] disp_addr, addr_q;
  logic [DATA_W-1:0] wdata_q, prefetch, char_q;
  assign wrap = x[9:4] == 6'd49;
  assign col = wrap ? 6'd0 : x[9:4] + 6'd1;
  assign row = wrap ? (y == 10'd524 ? 6'd0 : 6'((y + 10'd1) >> 4)) : y[9:4];
  assign disp_slot = x[3:0] == 4'(SLOT);
  assign in_map = 32'(col) < COLS && 32'(row) < ROWS;
  assign disp_acc = disp_slot && in_map;
  assign vis = col < 6'd40 && row < 6'd30;
  assign disp_addr = ADDR_W'(32'(row) * COLS + 32'(col));
  assign grant = state == IDLE && cpu_req && !disp_slot;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb
    state_n = grant ? CPU_ACK : IDLE;
  always_comb begin
    mem_addr = disp_acc ? disp_addr : grant ? cpu_addr : addr_q;
    mem_we = grant && cpu_we;
    mem_wdata = grant ? cpu_wdata : wdata_q;
    cpu_ack = state == CPU_ACK;
    cpu_rdata = state == CPU_ACK ? mem_rdata : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      addr_q <= '0;
      wdata_q <= '0;
      disp_pend <= 1'b0;
      prefetch <= '0;
      char_q <= '0;
    end else begin
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      disp_pend <= disp_acc;
      if (disp_slot && !in_map) prefetch <= '0;
      else if (disp_pend) prefetch <= mem_rdata;
      if (x[3:0] == 4'd15) char_q <= vis ? prefetch : '0;
    end
  assign char_code = activevideo ? char_q : '0;
`ifdef SMEM_STALL_CNT_EN
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (state == IDLE && cpu_req && disp_slot && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_smem_arbiter.sv
// tb_vga_smem_arbiter: randomized and directed checks of vga_smem_arbiter against a frame-level reference model
module tb_vga_smem_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] x, y;
  logic activevideo, cpu_req, cpu_we, cpu_ack, mem_we;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata, char_code;
  logic [15:0] stall_cnt;
  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];
  int n_chk = 0, n_fail = 0, exp_stall = 0, age = 0, lat = 0, acks;
  bit req_busy = 1'b0;
  vga_smem_arbiter dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .activevideo(activevideo),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .char_code(char_code), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, x, y);
    end
  endtask
  function automatic logic [7:0] exp_char(input int xx, input int yy);
    return (xx < 640 && yy < 480) ? ref_mem[(yy / 16) * 40 + xx / 16] : 8'h00;
  endfunction
  function automatic int stall_exp();
`ifdef SMEM_STALL_CNT_EN
    return exp_stall;
`else
    return 0;
`endif
  endfunction
  task automatic tick(input int xx, input int yy);
    @(posedge clk);
    #1;
    x = 10'(xx);
    y = 10'(yy);
    activevideo = xx < 640 && yy < 480;
  endtask
  task automatic cyc(input int xx, input int yy, input bit ck);
    tick(xx, yy);
    if (req_busy && age > lat) begin
      cpu_req = 1'b0;
      req_busy = 1'b0;
    end else if (!req_busy && $urandom_range(0, 3) == 0) begin
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = AW'($urandom_range(0, 2047));
      req_busy = 1'b1;
      age = 0;
      lat = (xx % 16 == 12) ? 2 : 1;
      if (lat == 2) exp_stall++;
    end
    @(negedge clk);
    if (ck) chk("char", char_code, exp_char(xx, yy));
    if (req_busy) begin
      chk("ack", cpu_ack, age == lat);
      if (age == lat) chk("rdata", cpu_rdata, ref_mem[cpu_addr]);
      age++;
    end else chk("idle_ack", cpu_ack, 0);
  endtask
  task automatic scan(input int yy);
    for (int i = 780; i < 800; i++) cyc(i, yy == 0 ? 524 : yy - 1, 1'b0);
    for (int i = 0; i < 800; i++) cyc(i, yy, 1'b1);
  endtask
  initial begin
    for (int k = 0; k < 2048; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[k] <= v;
      ref_mem[k] = v;
    end
    reset = 1'b1;
    x = 10'd5;
    y = 10'd0;
    activevideo = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_char", char_code, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_stall", stall_cnt, 0);
    for (int i = 600; i <= 796; i++) tick(i, 479);
    @(negedge clk);
    chk("row30_we", mem_we, 0);
    chk("row30_addr", mem_addr, 1199);
    for (int i = 797; i < 800; i++) tick(i, 479);
    tick(0, 480);
    @(negedge clk);
    chk("blank_char", char_code, 0);
    for (int i = 780; i <= 796; i++) tick(i, 524);
    @(negedge clk);
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_we", mem_we, 0);
    for (int i = 797; i < 800; i++) tick(i, 524);
    tick(0, 0);
    @(negedge clk);
    chk("wrap_char0", char_code, ref_mem[0]);
    for (int i = 84; i < 100; i++) tick(i, 50);
    tick(100, 50);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 11'd5;
    cpu_wdata = 8'hA5;
    @(negedge clk);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 5);
    chk("wr_data", mem_wdata, 8'hA5);
    chk("wr_noack", cpu_ack, 0);
    tick(101, 50);
    @(negedge clk);
    chk("wr_ack", cpu_ack, 1);
    ref_mem[5] = 8'hA5;
    tick(102, 50);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("wr_ackdrop", cpu_ack, 0);
    tick(103, 50);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    @(negedge clk);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 5);
    tick(104, 50);
    @(negedge clk);
    chk("rd_ack", cpu_ack, 1);
    chk("rd_data", cpu_rdata, ref_mem[5]);
    chk("rd_char", char_code, exp_char(104, 50));
    tick(105, 50);
    cpu_req = 1'b0;
    tick(106, 50);
    tick(107, 50);
    tick(108, 50);
    cpu_req = 1'b1;
    cpu_addr = 11'd9;
    exp_stall++;
    @(negedge clk);
    chk("st_dispaddr", mem_addr, 3 * 40 + 7);
    chk("st_we", mem_we, 0);
    chk("st_noack", cpu_ack, 0);
    tick(109, 50);
    @(negedge clk);
    chk("st_grant", mem_addr, 9);
    chk("st_noack2", cpu_ack, 0);
    tick(110, 50);
    @(negedge clk);
    chk("st_ack", cpu_ack, 1);
    chk("st_rdata", cpu_rdata, ref_mem[9]);
    tick(111, 50);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("st_cnt", stall_cnt, stall_exp());
    for (int i = 112; i < 129; i++) begin
      tick(i, 50);
      @(negedge clk);
      if (i == 112 || i == 127) chk("st_char", char_code, exp_char(i, 50));
    end
    acks = 0;
    cpu_addr = 11'd7;
    for (int i = 0; i < 10; i++) begin
      tick(129 + i, 50);
      cpu_req = 1'b1;
      @(negedge clk);
      chk("b2b_ack", cpu_ack, i % 2 == 1);
      if (cpu_ack) begin
        acks++;
        chk("b2b_rdata", cpu_rdata, ref_mem[7]);
      end
    end
    tick(139, 50);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("b2b_count", acks, 5);
    tick(200, 50);
    cpu_req = 1'b1;
    cpu_addr = 11'd20;
    reset = 1'b1;
    tick(201, 50);
    reset = 1'b0;
    cpu_req = 1'b0;
    exp_stall = 0;
    @(negedge clk);
    chk("mid_ack", cpu_ack, 0);
    chk("mid_rdata", cpu_rdata, 0);
    chk("mid_maddr", mem_addr, 0);
    chk("mid_mwe", mem_we, 0);
    chk("mid_mwdata", mem_wdata, 0);
    chk("mid_char", char_code, 0);
    chk("mid_stall", stall_cnt, 0);
    scan(0);
    scan(15);
    scan(16);
    scan(479);
    scan(480);
    for (int i = 0; i < 6; i++) scan($urandom_range(1, 478));
    tick(640, 500);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("end_stall", stall_cnt, stall_exp());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
